psram_qpi_responder: RTL and testbench
======================================

Name: psram_qpi_responder

Overview:
- Device-side responder for the PSRAM serial interface. It receives the commands that the controller and its init sequencer send, and tracks SPI versus QPI mode.
- Decodes Enter QPI (0x35), Exit QPI (0xF5), Quad Read (0xEB), Quad Write (0x38), Reset Enable (0x66) and Reset (0x99).
- Bridges reads and writes to a byte-wide asynchronous-read memory array.
- Sits inside the PSRAM model in perip/psram, facing the controller's sck/ce_n/dio pins.

Parameters:
- ADDR_W, 22, memory address width in bits; the 24-bit protocol address is truncated to ADDR_W bits.
- WAIT_CYCLES, 6, read dummy cycles between the last address nibble and the first data nibble; legal range 1..15.

Ports:
- clk  in  1  the PSRAM serial clock (sck); all sampling happens on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce_n  in  1  chip enable, active-low. While high, it asynchronously clears all transaction state except qpi_mode and rst_armed.
- din  in  4  data from the controller; only din[0] is used in SPI mode.
- dout  out  4  read data nibble.
- douten  out  1  output enable for dout.
- qpi_mode  out  1  1 = QPI mode active.
- mem_addr  out  ADDR_W  byte address to the memory array.
- mem_rdata  in  8  memory read data, combinational from mem_addr.
- mem_wdata  out  8  write data.
- mem_we  out  1  write strobe; the memory writes on the posedge where mem_we=1.

Behaviour:
- Reset values: qpi_mode=0, rst_armed=0, state=CMD, douten=0, dout=0, mem_we=0, mem_addr=0.
- Edge numbering: k = index of the posedge with ce_n low, counting from 0 at the first edge of the transaction.
- States: CMD, ADDR, WAIT, RDATA, WDATA, IGNORE. An async ce_n rise returns to CMD with the counter at 0.
- CMD state, SPI mode:
  - Shift din[0] MSB-first over edges 0..7.
  - Decode on edge 7: 0x35 sets qpi_mode; 0x66 sets rst_armed; 0x99 with rst_armed=1 clears qpi_mode.
  - Any other command goes to IGNORE.
- CMD state, QPI mode:
  - Shift din[3:0], high nibble first, over edges 0..1.
  - Decode on edge 1:
    - 0xF5 clears qpi_mode; next state IGNORE.
    - 0x35 is a no-op; next state IGNORE.
    - 0xEB goes to ADDR with rd=1.
    - 0x38 goes to ADDR with rd=0.
    - 0x66 sets rst_armed; next state IGNORE.
    - 0x99 with rst_armed=1 clears qpi_mode; next state IGNORE.
    - Anything else goes to IGNORE.
- rst_armed handling:
  - Cleared at the decode of every command other than 0x66.
  - 0x99 without rst_armed is ignored.
- ADDR state:
  - 6 nibbles on edges 2..7, MSB first, into a 24-bit address register.
  - On edge 7, mem_addr takes the final address (combinationally from shift-register plus din, or registered; the address must be valid after edge 7).
  - Next state: WAIT if rd=1, WDATA if rd=0.
- WAIT state:
  - Covers edges 8..8+WAIT_CYCLES-1; douten stays 0.
  - On the last wait edge, enter RDATA with phase=0.
- RDATA state:
  - douten=1, registered.
  - dout = mem_rdata[7:4] when phase=0, mem_rdata[3:0] when phase=1.
  - Each edge toggles phase; after phase=1 the edge increments mem_addr modulo 2^ADDR_W.
  - The first data nibble is driven in the cycle after edge 7+WAIT_CYCLES; it is the high nibble of byte A.
  - Reads continue until ce_n rises.
- WDATA state:
  - Edges alternate hi/lo. The hi nibble is latched.
  - On the lo edge, mem_we=1 (combinational: state==WDATA && phase==1 && !ce_n) with mem_wdata={hi,din}; the same edge increments mem_addr, wrapping modulo 2^ADDR_W.
  - A partial byte at ce_n rise is discarded (no write).
- IGNORE state: no outputs; held until ce_n rises.
- ce_n rise mid-operation:
  - douten drops asynchronously.
  - No memory write occurs after the rise.
  - qpi_mode is never altered by an abort.
- Mode changes take effect at the decode edge. The next transaction uses the new width.
- rst_n low mid-transaction returns everything to reset values.

Decomposition:
- Package psram_pkg holds:
  - Command constants CMD_ENTER_QPI=0x35, CMD_EXIT_QPI=0xF5, CMD_QREAD=0xEB, CMD_QWRITE=0x38, CMD_RSTEN=0x66, CMD_RST=0x99.
  - The state enum.
  - ADDR_NIBBLES=6.
- A single module; no sub-module is needed. The nibble/bit shift register stays inline.

Test Plan:
- Reset, then SPI bits 0,0,1,1,0,1,0,1 on din[0] over 8 edges -> qpi_mode=1 after edge 7; douten=0 throughout.
- QPI 0xEB, addr 0x000010, mem[0x10]=0xA5, mem[0x11]=0x3C, WAIT_CYCLES=6 -> douten=1 from the cycle after edge 13; dout=A,5,3,C on successive cycles.
- QPI 0x38, addr 0x3FFFFF, data nibbles 1,2,3,4 -> mem[0x3FFFFF]=0x12 and mem[0x000000]=0x34 (wrap). Then 0x38 to 0x100 with a single nibble then ce_n high -> mem[0x100] unchanged.
- QPI 0x66 transaction, then 0x99 -> qpi_mode=0. Separately, 0x66, 0xEB read, 0x99 -> qpi_mode stays 1.
- QPI read aborted by ce_n high at edge 15 -> douten=0 immediately. The next 0xEB transaction decodes correctly from edge 0.
- QPI unknown command 0x12 and SPI 0xEB -> IGNORE; douten=0, mem_we=0, qpi_mode unchanged.

Source files
------------

// File: rtl/psram_qpi_responder_pkg.sv
// psram_pkg: command codes, FSM states and protocol constants for the PSRAM responder
package psram_pkg;
  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_RSTEN     = 8'h66;
  localparam logic [7:0] CMD_RST       = 8'h99;
  localparam int ADDR_NIBBLES = 6;
  typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_WAIT, ST_RDATA, ST_WDATA, ST_IGNORE} state_t;
endpackage

// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: PSRAM device-side SPI/QPI command responder bridging to a byte memory
//   clk/rst_n : serial clock (sck), async active-low reset
//   ce_n      : chip enable; high asynchronously aborts the transaction (mode kept)
//   din       : controller data (din[0] only in SPI mode)
//   dout/douten : read nibble and its output enable
//   qpi_mode  : 1 while QPI mode is active
//   mem_*     : byte memory port, async read, write on posedge with mem_we
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_n,
  input  logic [3:0]        din,
  output logic [3:0]        dout,
  output logic              douten,
  output logic              qpi_mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we
);
  localparam logic [4:0] ADDR_END  = 5'(1 + ADDR_NIBBLES);
  localparam logic [4:0] LAST_WAIT = 5'(1 + ADDR_NIBBLES + WAIT_CYCLES);
  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [19:0]       r_sr;
  logic              r_rd, r_phase, r_douten, r_qpi, r_armed;
  logic [3:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic              w_clr, w_dec;
  logic [7:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  // transaction state is cleared by either reset or a deasserted chip enable
  assign w_clr  = ~rst_n | ce_n;
  assign w_cmd  = r_qpi ? {r_sr[3:0], din} : {r_sr[6:0], din[0]};
  assign w_dec  = !ce_n && r_state == ST_CMD && r_cnt == (r_qpi ? 5'd1 : 5'd7);
  assign w_addr = ADDR_W'({r_sr, din});
  assign mem_addr  = r_addr;
  assign mem_wdata = {r_hi, din};
  assign mem_we    = r_state == ST_WDATA && r_phase && !ce_n;
  assign douten    = r_douten;
  assign dout      = r_douten ? (r_phase ? mem_rdata[3:0] : mem_rdata[7:4]) : 4'd0;
  assign qpi_mode  = r_qpi;
  // mode and reset-arm survive chip-enable aborts, so only rst_n clears them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_qpi   <= 1'b0;
      r_armed <= 1'b0;
    end else if (w_dec) begin
      r_armed <= w_cmd == CMD_RSTEN;
      r_qpi   <= w_cmd == CMD_ENTER_QPI ? 1'b1 :
                 (w_cmd == CMD_EXIT_QPI || (w_cmd == CMD_RST && r_armed)) ? 1'b0 : r_qpi;
    end
  always_ff @(posedge clk or posedge w_clr)
    if (w_clr) begin
      r_state  <= ST_CMD;
      r_cnt    <= 5'd0;
      r_sr     <= 20'd0;
      r_rd     <= 1'b0;
      r_phase  <= 1'b0;
      r_douten <= 1'b0;
      r_hi     <= 4'd0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        ST_CMD: begin
          r_cnt <= r_cnt + 5'd1;
          r_sr  <= r_qpi ? {r_sr[15:0], din} : {r_sr[18:0], din[0]};
          r_rd  <= w_cmd == CMD_QREAD;
          if (w_dec)
            r_state <= r_qpi && (w_cmd == CMD_QREAD || w_cmd == CMD_QWRITE) ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: begin
          r_cnt <= r_cnt + 5'd1;
          r_sr  <= {r_sr[15:0], din};
          if (r_cnt == ADDR_END) begin
            r_addr  <= w_addr;
            r_phase <= 1'b0;
            r_state <= r_rd ? ST_WAIT : ST_WDATA;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_WAIT) begin
            r_state  <= ST_RDATA;
            r_douten <= 1'b1;
            r_phase  <= 1'b0;
          end
        end
        ST_RDATA: begin
          r_phase <= ~r_phase;
          if (r_phase) r_addr <= r_addr + 1'b1;
        end
        ST_WDATA: begin
          r_phase <= ~r_phase;
          if (!r_phase) r_hi <= din;
          if (r_phase) r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: randomized scoreboard bench for the PSRAM SPI/QPI responder
module tb_psram_qpi_responder;
  localparam int AW  = 22;
  localparam int W   = 6;
  localparam int MSZ = 1 << AW;
  logic          clk = 1'b0, rst_n = 1'b0, ce_n = 1'b1;
  logic [3:0]    din = 4'd0;
  logic [3:0]    dout;
  logic          douten, qpi_mode, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata, mem_wdata;
  logic [7:0]    mem [MSZ];
  logic [7:0]    model [int];
  logic          m_qpi = 1'b0, m_armed = 1'b0;
  logic [3:0]    exp_q [$];
  logic [3:0]    nq [$];
  logic [7:0]    c;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  psram_qpi_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .din(din), .dout(dout), .douten(douten),
    .qpi_mode(qpi_mode), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  function automatic logic [7:0] init_b(input int a);
    return 8'(a * 37 + (a >> 8) * 11 + 5);
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    return model.exists(a) ? model[a] : init_b(a);
  endfunction

  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int i = 0; i < MSZ; i++) mem[i] = init_b(i);
    mem[16] = 8'hA5;
    mem[17] = 8'h3C;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (douten) begin
      if (exp_q.size() == 0) chk("douten_unexpected", douten, 0);
      else chk("rd_nibble", dout, exp_q.pop_front());
    end

  task automatic put(input logic [3:0] d);
    @(negedge clk);
    #1;
    ce_n = 1'b0;
    din  = d;
  endtask

  task automatic finish_tx(input string nm);
    @(negedge clk);
    #1;
    ce_n = 1'b1;
    din  = 4'($urandom);
    #1;
    chk({nm, "_douten_off"}, douten, 0);
    chk({nm, "_we_off"}, mem_we, 0);
    chk({nm, "_qpi_mode"}, qpi_mode, m_qpi);
    chk({nm, "_sb_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // reference command semantics: mode and reset-arm effects of a decoded command
  task automatic m_cmd(input logic [7:0] cc);
    if (cc == 8'h35) m_qpi = 1'b1;
    else if (cc == 8'hF5 || (cc == 8'h99 && m_armed)) m_qpi = 1'b0;
    m_armed = cc == 8'h66;
  endtask

  task automatic send_cmd(input logic [7:0] cc);
    if (m_qpi) begin
      put(cc[7:4]);
      put(cc[3:0]);
    end else
      for (int i = 7; i >= 0; i--) put({3'($urandom), cc[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) put(a[4*i +: 4]);
  endtask

  task automatic simple_cmd(input logic [7:0] cc, input int extra);
    send_cmd(cc);
    m_cmd(cc);
    repeat (extra) begin
      put(4'($urandom));
      chk("ignore_we", mem_we, 0);
    end
    finish_tx("cmd");
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int b;
    logic [7:0] v;
    b = int'(a[AW-1:0]);
    send_cmd(8'hEB);
    m_cmd(8'hEB);
    send_addr(a);
    repeat (W) put(4'($urandom));
    for (int j = 0; j < n; j++) begin
      v = m_rd((b + j / 2) % MSZ);
      exp_q.push_back(j % 2 == 1 ? v[3:0] : v[7:4]);
    end
    repeat (n - 1) put(4'($urandom));
    finish_tx("rd");
  endtask

  task automatic do_write(input logic [23:0] a, input logic [3:0] nib [$]);
    int b, x, n;
    b = int'(a[AW-1:0]);
    n = nib.size();
    send_cmd(8'h38);
    m_cmd(8'h38);
    send_addr(a);
    for (int j = 0; j < n; j++) put(nib[j]);
    finish_tx("wr");
    for (int k = 0; k < n / 2; k++) begin
      x = (b + k) % MSZ;
      model[x] = {nib[2*k], nib[2*k+1]};
      chk("mem_write", mem[x], model[x]);
    end
    if (n % 2 == 1) begin
      x = (b + n / 2) % MSZ;
      chk("partial_discarded", mem[x], m_rd(x));
    end
  endtask

  function automatic logic [23:0] rand_addr();
    logic [21:0] l;
    l = ($urandom_range(0, 3) == 0) ? 22'h3FFFFE + 22'($urandom_range(0, 3))
                                    : 22'h200 + 22'($urandom_range(0, 31));
    return {2'($urandom), l};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model[16] = 8'hA5;
    model[17] = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_qpi", qpi_mode, 0);
    chk("rst_douten", douten, 0);
    chk("rst_dout", dout, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    #1 rst_n = 1'b1;
    // SPI enter-QPI, mode must flip only at the decode edge
    for (int i = 7; i >= 0; i--) put({3'b000, 1'((8'h35 >> i) & 1)});
    chk("spi_qpi_before_decode", qpi_mode, 0);
    m_cmd(8'h35);
    finish_tx("spi35");
    do_read(24'h000010, 4);
    nq = {4'h1, 4'h2, 4'h3, 4'h4};
    do_write(24'h3FFFFF, nq);
    chk("wrap_top_byte", mem[22'h3FFFFF], 8'h12);
    chk("wrap_zero_byte", mem[0], 8'h34);
    nq = {4'h7};
    do_write(24'h000100, nq);
    chk("single_nibble_no_write", mem[22'h100], init_b(32'h100));
    simple_cmd(8'h66, 0);
    simple_cmd(8'h99, 0);
    chk("reset_seq_left_qpi", qpi_mode, 0);
    simple_cmd(8'h35, 0);
    simple_cmd(8'h66, 0);
    do_read(24'h000011, 2);
    simple_cmd(8'h99, 0);
    chk("unarmed_reset_keeps_qpi", qpi_mode, 1);
    do_read(24'h000020, 2);
    do_read(24'h000010, 3);
    simple_cmd(8'h12, 3);
    simple_cmd(8'hF5, 0);
    simple_cmd(8'hEB, 4);
    simple_cmd(8'h35, 0);
    repeat (60) begin
      int op;
      op = $urandom_range(0, 9);
      if (!m_qpi) simple_cmd($urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h35, $urandom_range(0, 2));
      else if (op < 4) do_read(rand_addr(), $urandom_range(1, 9));
      else if (op < 7) begin
        nq.delete();
        repeat ($urandom_range(1, 7)) nq.push_back(4'($urandom));
        do_write(rand_addr(), nq);
      end else begin
        case ($urandom_range(0, 4))
          0: c = 8'h66;
          1: c = 8'h99;
          2: c = 8'hF5;
          3: c = 8'h35;
          default: c = 8'($urandom);
        endcase
        if (c == 8'hEB || c == 8'h38) c = 8'h12;
        simple_cmd(c, $urandom_range(0, 3));
      end
    end
    if (!m_qpi) simple_cmd(8'h35, 0);
    send_cmd(8'hEB);
    send_addr(24'h000010);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midtx_rst_qpi", qpi_mode, 0);
    chk("midtx_rst_douten", douten, 0);
    chk("midtx_rst_addr", mem_addr, 0);
    m_qpi = 1'b0;
    m_armed = 1'b0;
    ce_n = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    simple_cmd(8'h35, 0);
    do_read(24'h3FFFFF, 4);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
